// File: rtl/herald_pkg.sv
// Shared constants for the Herald engine scheduler: opcodes, Q12.12 widths, FSM states.
package herald_pkg;

  localparam int Q_INT_BITS  = 12;
  localparam int Q_FRAC_BITS = 12;
  localparam int Q_W         = Q_INT_BITS + Q_FRAC_BITS;

  localparam logic [7:0] CMD_SINCOS = 8'h10;
  localparam logic [7:0] CMD_ATAN   = 8'h11;
  localparam logic [7:0] CMD_MAG    = 8'h12;
  localparam logic [7:0] CMD_MUL    = 8'h20;
  localparam logic [7:0] CMD_MAC    = 8'h21;
  localparam logic [7:0] CMD_CLEAR  = 8'h22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FETCH,
    ST_RESP
  } sched_state_e;

endpackage

// File: rtl/herald_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping at NREQ-1.
module herald_rr_arbiter
  import herald_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      idx,
  output logic            any
);

  // Scan from the far end back toward ptr so the closest requester wins
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        grant                              = '0;
        grant[(int'(ptr) + k) % NREQ]      = 1'b1;
        idx                                = 3'((int'(ptr) + k) % NREQ);
        any                                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/herald_engine_scheduler.sv
// Shares one Herald compute engine among NREQ requesters: round-robin grant,
// start/wait/fetch engine handshake with timeout, and routed response.
module herald_engine_scheduler
  import herald_pkg::*;
#(
  parameter int         NREQ     = 4,
  parameter int         DW       = Q_W,
  parameter int         RW       = 48,
  parameter int         TIMEOUT  = 255,
  parameter logic [7:0] NORES_OP = CMD_CLEAR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [8*NREQ-1:0]  req_op,
  input  logic [DW*NREQ-1:0] req_a,
  input  logic [DW*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [RW-1:0]      rsp_data,
  output logic               rsp_err,
  output logic               eng_start,
  output logic [7:0]         eng_op,
  output logic [DW-1:0]      eng_a,
  output logic [DW-1:0]      eng_b,
  input  logic               eng_busy,
  output logic               eng_get,
  input  logic               eng_get_rdy,
  input  logic [RW-1:0]      eng_result,
  output logic [2:0]         grant_id,
  output logic               sched_busy
);

  localparam int TW = 16;

  sched_state_e  state_q, state_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic [2:0]    gid_q, gid_d;
  logic [7:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [RW-1:0] res_q, res_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic          tmo_hit, rsp_hs;

  logic [NREQ-1:0] arb_grant;
  logic [2:0]      arb_idx;
  logic            arb_any;
  logic [7:0]      op_sel;
  logic [DW-1:0]   a_sel, b_sel;

  herald_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Steer the winning requester's command onto the latch inputs
  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_grant[k]) begin
        op_sel = req_op[k*8 +: 8];
        a_sel  = req_a[k*DW +: DW];
        b_sel  = req_b[k*DW +: DW];
      end
    end
  end

  // Timeout fires on the TIMEOUT-th cycle spent in WAIT/FETCH
  always_comb begin
    tmo_inc = tmo_q + TW'(1);
    tmo_hit = (TIMEOUT != 0) && (tmo_inc == TW'(TIMEOUT)) &&
              (state_q == ST_WAIT || state_q == ST_FETCH);
  end

  // Output decode; req_ready is forced low while reset is held
  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      rsp_valid[k] = (state_q == ST_RESP) && (gid_q == 3'(k));
    end
    rsp_hs     = |(rsp_valid & rsp_ready);
    req_ready  = (state_q == ST_IDLE && !rst) ? arb_grant : '0;
    eng_start  = (state_q == ST_ISSUE);
    eng_get    = (state_q == ST_FETCH) && !tmo_hit;
    sched_busy = (state_q != ST_IDLE);
    rsp_data   = res_q;
    rsp_err    = err_q;
    eng_op     = op_q;
    eng_a      = a_q;
    eng_b      = b_q;
    grant_id   = gid_q;
  end

  // Next-state and register updates; first WAIT cycle (tmo_q==0) ignores eng_busy
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gid_d    = gid_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          op_d     = op_sel;
          a_d      = a_sel;
          b_d      = b_sel;
          gid_d    = arb_idx;
          rr_ptr_d = (arb_idx == 3'(NREQ - 1)) ? 3'd0 : arb_idx + 3'd1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        err_d = 1'b0;
        tmo_d = '0;
        if (op_q == NORES_OP) begin
          res_d   = '0;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (tmo_q != '0 && !eng_busy) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (eng_get_rdy) begin
          res_d   = eng_result;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_herald_engine_scheduler.sv
// Self-checking bench for herald_engine_scheduler: directed scenarios plus
// randomized transactions against a cycle-level transaction model.
module tb_herald_engine_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 24;
  localparam int RW   = 48;
  localparam int TMO  = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [8*NREQ-1:0]   req_op;
  logic [DW*NREQ-1:0]  req_a, req_b;
  logic [RW-1:0]       rsp_data, eng_result;
  logic                rsp_err, eng_start, eng_busy, eng_get, eng_get_rdy, sched_busy;
  logic [7:0]          eng_op;
  logic [DW-1:0]       eng_a, eng_b;
  logic [2:0]          grant_id;

  int n_checks = 0;
  int n_pass   = 0;
  int model_ptr = 0;

  logic [7:0]    op_r [NREQ];
  logic [DW-1:0] a_r  [NREQ];
  logic [DW-1:0] b_r  [NREQ];
  logic [RW-1:0] res_v;

  always #5 clk = ~clk;

  herald_engine_scheduler #(
    .NREQ(NREQ), .DW(DW), .RW(RW), .TIMEOUT(TMO), .NORES_OP(8'h22)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_op(eng_op), .eng_a(eng_a), .eng_b(eng_b),
    .eng_busy(eng_busy), .eng_get(eng_get), .eng_get_rdy(eng_get_rdy), .eng_result(eng_result),
    .grant_id(grant_id), .sched_busy(sched_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_op[8*i +: 8]  = op_r[i];
      req_a[DW*i +: DW] = a_r[i];
      req_b[DW*i +: DW] = b_r[i];
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_req_ready"}, req_ready, 0);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_rsp_data"}, rsp_data, 0);
    chk({pfx, "_rsp_err"}, rsp_err, 0);
    chk({pfx, "_eng_start"}, eng_start, 0);
    chk({pfx, "_eng_get"}, eng_get, 0);
    chk({pfx, "_eng_op"}, eng_op, 0);
    chk({pfx, "_eng_a"}, eng_a, 0);
    chk({pfx, "_eng_b"}, eng_b, 0);
    chk({pfx, "_grant_id"}, grant_id, 0);
    chk({pfx, "_sched_busy"}, sched_busy, 0);
  endtask

  // Entered just after a negedge with the scheduler idle. Cycle 0 is the grant cycle.
  // Engine model: busy for bsy cycles after the start pulse, result ready dly cycles
  // into the fetch. tmo_mode keeps busy high forever.
  task automatic do_txn(input logic [NREQ-1:0] mask, input int bsy, input int dly,
                        input int hold, input bit tmo_mode, output int g);
    int t, lat, c, gcnt;
    bit nores, seen, exp_get;
    logic [RW-1:0] exp_d;
    logic [RW-1:0] held_d;
    logic [NREQ-1:0] gmask;
    drive_ops();
    req_valid = mask;
    #1;
    g = rr_pick(mask, model_ptr);
    gmask = NREQ'(1 << g);
    chk("grant_onehot", req_ready, gmask);
    chk("idle_not_busy", sched_busy, 0);
    @(posedge clk);
    model_ptr = (g + 1) % NREQ;
    @(negedge clk);
    req_valid = mask & ~gmask;
    nores = (op_r[g] == 8'h22);
    t     = (bsy + 2 > 3) ? bsy + 2 : 3;
    lat   = nores ? 2 : (tmo_mode ? 2 + TMO : t + 2 + dly);
    exp_d = (nores || tmo_mode) ? '0 : res_v;
    gcnt = 0;
    seen = 0;
    for (c = 1; c <= 40; c++) begin
      eng_busy    = tmo_mode ? (c >= 2) : (c >= 2 && c <= bsy + 1);
      eng_get_rdy = (!tmo_mode && eng_get && gcnt >= dly);
      if (eng_get) gcnt++;
      eng_result  = eng_get_rdy ? res_v : {$urandom, $urandom} >> 16;
      #1;
      if (rsp_valid != 0) begin
        seen = 1;
        break;
      end
      if (c == 1) begin
        chk("eng_start", eng_start, 1);
        chk("eng_op", eng_op, op_r[g]);
        chk("eng_a", eng_a, a_r[g]);
        chk("eng_b", eng_b, b_r[g]);
        chk("grant_id", grant_id, g);
      end else begin
        chk("start_single", eng_start, 0);
      end
      chk("busy_flag", sched_busy, 1);
      chk("held_off", req_ready, 0);
      exp_get = !nores && !tmo_mode && c >= t + 1 && c <= t + 1 + dly;
      chk("eng_get", eng_get, exp_get);
      @(negedge clk);
    end
    chk("rsp_seen", seen, 1);
    if (tmo_mode) chk("tmo_latency_ok", (c == lat || c == lat + 1), 1);
    else          chk("latency", c, lat);
    chk("rsp_valid", rsp_valid, gmask);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_err", rsp_err, tmo_mode);
    chk("rsp_get_low", eng_get, 0);
    held_d = rsp_data;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = NREQ'($urandom) & ~gmask;
      @(negedge clk);
      #1;
      chk("hold_valid", rsp_valid, gmask);
      chk("hold_data", rsp_data, held_d);
      chk("hold_no_grant", req_ready, 0);
    end
    rsp_ready = gmask;
    @(posedge clk);
    @(negedge clk);
    rsp_ready   = '0;
    eng_busy    = 1'b0;
    eng_get_rdy = 1'b0;
    #1;
    chk("rsp_dropped", rsp_valid, 0);
    chk("back_idle", sched_busy, 0);
  endtask

  initial begin
    int g;
    logic [NREQ-1:0] m;
    rst = 1'b1;
    req_valid = '0; rsp_ready = '0; eng_busy = 1'b0; eng_get_rdy = 1'b0; eng_result = '0;
    for (int i = 0; i < NREQ; i++) begin op_r[i] = 8'h20; a_r[i] = '0; b_r[i] = '0; end
    res_v = '0;
    drive_ops();
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // All four requesters continuously valid: strict rotation
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < NREQ; r++) op_r[r] = 8'(16 + $urandom_range(0, 17));
      res_v = {$urandom, $urandom} >> 16;
      do_txn('1, $urandom_range(0, 2), $urandom_range(0, 2), 0, 0, g);
      chk("rr_order", g, i % NREQ);
    end

    // Single requester, minimum latency
    req_valid = '0;
    op_r[0] = 8'h20; a_r[0] = 24'h001000; b_r[0] = 24'h002000; res_v = 48'h2000;
    do_txn(4'b0001, 0, 0, 0, 0, g);

    // No-result opcode
    op_r[2] = 8'h22; res_v = 48'hABCDEF;
    do_txn(4'b0100, 0, 0, 2, 0, g);

    // Engine stuck busy -> timeout error response
    op_r[3] = 8'h21;
    do_txn(4'b1000, 0, 0, 1, 1, g);

    // Long response back-pressure with req1 pending
    op_r[0] = 8'h10; op_r[1] = 8'h11; res_v = 48'h123456789ABC;
    do_txn(4'b0011, 1, 1, 10, 0, g);
    chk("bp_owner", g, 0);

    // Reset in WAIT: abort, then rr pointer rescans from 0
    drive_ops();
    req_valid = 4'b0010;
    #1;
    chk("pre_rst_grant", req_ready, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b1010;
    eng_busy  = 1'b1;
    @(negedge clk);
    #1;
    chk("in_wait_busy", sched_busy, 1);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    eng_busy = 1'b0;
    model_ptr = 0;
    op_r[3] = 8'h12;
    res_v = 48'h5555;
    do_txn(4'b1010, 0, 0, 0, 0, g);
    chk("rst_regrant", g, 1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      m = req_valid | NREQ'($urandom_range(0, 15));
      if (m == 0) m = NREQ'(1 << $urandom_range(0, NREQ - 1));
      for (int r = 0; r < NREQ; r++) begin
        if (!req_valid[r]) begin
          op_r[r] = 8'(16 + $urandom_range(0, 18));
          a_r[r]  = DW'($urandom);
          b_r[r]  = DW'($urandom);
        end
      end
      res_v = {$urandom, $urandom} >> 16;
      do_txn(m, $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 3), 0, g);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
